// File: rtl/sync_fifo_fwft_pkg.sv
// Shared types and width helpers for the single-clock FIFO.
package sync_fifo_fwft_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// Simple dual-port storage: one write port, one registered read port (read-before-write).
module sync_fifo_fwft_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with level/threshold flags, sticky error flags, synchronous flush
// and a selectable standard or first-word-fall-through read port.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic                    i_w_en,
    input  logic [DATA_WIDTH-1:0]   i_data_in,
    input  logic                    i_r_en,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_data_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int         PW   = ptr_width(DEPTH);
    localparam int         CW   = count_width(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_fwft: DEPTH must be a power of 2 and >= 2");
        end
        if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
            $error("sync_fifo_fwft: AF_THRESH must be in 1..DEPTH");
        end
        if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_fwft: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [PW:0]            r_wptr;
    logic [PW:0]            r_rptr;
    logic [PW:0]            w_wptr_next;
    logic [PW:0]            w_rptr_next;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   r_overflow;
    logic                   r_underflow;
    logic [CW-1:0]          w_count;
    logic                   w_ram_re;
    logic [PW-1:0]          w_ram_raddr;
    logic [DATA_WIDTH-1:0]  w_ram_rdata;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_wr_acc = i_w_en & ~w_full  & ~i_flush;
    assign w_rd_acc = i_r_en & ~w_empty & ~i_flush;
    assign w_count  = r_wptr - r_rptr;

    always_comb begin
        w_wptr_next = r_wptr + {{PW{1'b0}}, w_wr_acc};
        w_rptr_next = r_rptr + {{PW{1'b0}}, w_rd_acc};
        if (i_flush) begin
            w_wptr_next = '0;
            w_rptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            if (i_flush) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (i_w_en && w_full) begin
                    r_overflow <= 1'b1;
                end
                if (i_r_en && w_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_count        = w_count;
    assign o_almost_full  = (w_count >= CW'(AF_THRESH));
    assign o_almost_empty = (w_count <= CW'(AE_THRESH));
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

    sync_fifo_fwft_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[PW-1:0]),
        .i_wdata (i_data_in),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            logic                  r_byp;
            logic [DATA_WIDTH-1:0] r_byp_data;
            logic [DATA_WIDTH-1:0] r_hold;
            logic [DATA_WIDTH-1:0] w_head;

            // RAM continuously prefetches the next head; a write landing on that same
            // slot this edge is not visible through the RAM yet, so forward it instead.
            assign w_ram_re    = 1'b1;
            assign w_ram_raddr = w_rptr_next[PW-1:0];
            assign w_head      = r_byp ? r_byp_data : w_ram_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_byp      <= 1'b0;
                    r_byp_data <= '0;
                    r_hold     <= '0;
                end else if (i_flush) begin
                    r_byp      <= 1'b0;
                    r_byp_data <= '0;
                    r_hold     <= '0;
                end else begin
                    r_byp      <= w_wr_acc && (r_wptr[PW-1:0] == w_rptr_next[PW-1:0]);
                    r_byp_data <= i_data_in;
                    if (w_rd_acc) begin
                        r_hold <= w_head;
                    end
                end
            end

            assign o_data_out   = w_empty ? r_hold : w_head;
            assign o_data_valid = ~w_empty;
        end else begin : g_std
            logic                  r_dv;
            logic [DATA_WIDTH-1:0] r_hold;

            assign w_ram_re    = w_rd_acc;
            assign w_ram_raddr = r_rptr[PW-1:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dv   <= 1'b0;
                    r_hold <= '0;
                end else if (i_flush) begin
                    r_dv   <= 1'b0;
                    r_hold <= '0;
                end else begin
                    r_dv <= w_rd_acc;
                    if (r_dv) begin
                        r_hold <= w_ram_rdata;
                    end
                end
            end

            // The RAM output register is not resettable, so idle/reset/flush value comes from r_hold.
            assign o_data_out   = r_dv ? w_ram_rdata : r_hold;
            assign o_data_valid = r_dv;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and scores both
// against a queue-based reference model.
module tb_sync_fifo_fwft;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          flush  = 1'b0;
    logic          w_en   = 1'b0;
    logic          r_en   = 1'b0;
    logic [DW-1:0] din    = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0]    s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_w_en(w_en), .i_data_in(din), .i_r_en(r_en),
        .o_data_out(s_dout), .o_data_valid(s_dv), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_udf)
    );

    sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_w_en(w_en), .i_data_in(din), .i_r_en(r_en),
        .o_data_out(f_dout), .o_data_valid(f_dv), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_udf)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_std[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    logic [DW-1:0] std_hold  = '0;
    logic [DW-1:0] fwft_hold = '0;
    logic [DW-1:0] mon_e;
    bit            chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {count, empty, full, almost_full, almost_empty, overflow, underflow}.
    function automatic logic [9:0] exp_flags();
        int n;
        n = mq.size();
        return {4'(n), (n == 0), (n == DEPTH), (n >= AF), (n <= AE), m_ovf, m_udf};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("std_flags",  32'({s_count, s_empty, s_full, s_af, s_ae, s_ovf, s_udf}), 32'(exp_flags()));
            check("fwft_flags", 32'({f_count, f_empty, f_full, f_af, f_ae, f_ovf, f_udf}), 32'(exp_flags()));
            check("std_valid", 32'(s_dv), 32'(exp_std.size() != 0));
            if (exp_std.size() != 0) begin
                mon_e = exp_std.pop_front();
                check("std_data", 32'(s_dout), 32'(mon_e));
                std_hold = mon_e;
            end else begin
                check("std_hold", 32'(s_dout), 32'(std_hold));
            end
            check("fwft_valid", 32'(f_dv), 32'(mq.size() != 0));
            check("fwft_data", 32'(f_dout), 32'((mq.size() != 0) ? mq[0] : fwft_hold));
        end
    end

    task automatic step(input bit we, input bit re, input bit fl, input logic [DW-1:0] d);
        bit fm;
        bit em;
        @(negedge clk);
        w_en  = we;
        r_en  = re;
        flush = fl;
        din   = d;
        fm = (mq.size() == DEPTH);
        em = (mq.size() == 0);
        $display("txn t=%0t we=%0d re=%0d flush=%0d din=%02h model_count=%0d", $time, we, re, fl, d, mq.size());
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            std_hold  = '0;
            fwft_hold = '0;
        end else begin
            if (re && !em) begin
                exp_std.push_back(mq[0]);
                fwft_hold = mq.pop_front();
            end
            if (we && !fm) mq.push_back(d);
            if (we && fm)  m_ovf = 1'b1;
            if (re && em)  m_udf = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_std_flags"},  32'({s_count, s_empty, s_full, s_af, s_ae, s_ovf, s_udf}), 32'(10'b0000_1_0_0_1_0_0));
        check({tag, "_fwft_flags"}, 32'({f_count, f_empty, f_full, f_af, f_ae, f_ovf, f_udf}), 32'(10'b0000_1_0_0_1_0_0));
        check({tag, "_std_out"},  32'({s_dv, s_dout}), 32'(0));
        check({tag, "_fwft_out"}, 32'({f_dv, f_dout}), 32'(0));
    endtask

    task automatic async_reset();
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        exp_std.delete();
        m_ovf = 1'b0; m_udf = 1'b0; std_hold = '0; fwft_hold = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("init_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill to full, then one write too many.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 1'b0, 8'h99);
        // Drain, then one read too many.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Steady level of 4 with concurrent push/pop across several wraps.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Single word into an empty FIFO falls through without a read.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Level 5 with overflow set, then flush beats a same-cycle write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        step(1'b1, 1'b0, 1'b0, 8'hEE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), 8'($urandom));

        async_reset();
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
